// File: rtl/pipeline_input.sv
// pipeline_input: consumer stage for the pipeline output stream.
// Beats enter a 2-entry FIFO over valid/ready. Ready comes from a flop.
// The FIFO drains whenever i_hold is low, and consumed-beat statistics are kept.
// Optional feature macro: PIPELINE_INPUT_CHECK_EN enables the increment-by-one
// sequence checker. Without it, o_error and o_err_count are tied to zero.
module pipeline_input #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_hold,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_last,
  output logic             o_error,
  output logic [7:0]       o_err_count
);

  logic [WIDTH-1:0] r_mem [0:1];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic             r_ready;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_last;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_occ_nxt;
  logic [WIDTH-1:0] w_head;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = (r_occ != 2'd0) & ~i_hold;
  assign w_head  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;
  assign o_count = r_count;
  assign o_last  = r_last;

  // Next occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_push && !w_pop) begin
      w_occ_nxt = r_occ + 2'd1;
    end else if (!w_push && w_pop) begin
      w_occ_nxt = r_occ - 2'd1;
    end
  end

  // FIFO control. Ready is registered from next occupancy, so it never depends on the stall input combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ   <= w_occ_nxt;
      r_ready <= (w_occ_nxt != 2'd2);
    end
  end

  // FIFO storage. It is unreset because occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_value;
    end
  end

  // Consumed-beat statistics. A clear wins over counting, but the popped value still reaches o_last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_pop) begin
        r_last <= w_head;
      end
      if (i_clear) begin
        r_count <= '0;
      end else if (w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

`ifdef PIPELINE_INPUT_CHECK_EN
  logic [WIDTH-1:0] r_expected;
  logic             r_error;
  logic [7:0]       r_err_count;
  logic             w_mismatch;

  // Saturating increment for the mismatch counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_mismatch  = (w_head != r_expected);
  assign o_error     = r_error;
  assign o_err_count = r_err_count;

  // Sequence checker. Expected resynchronises to head+1 on every counted pop, matched or not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_expected  <= '0;
      r_error     <= 1'b0;
      r_err_count <= 8'd0;
    end else if (i_clear) begin
      r_expected  <= '0;
      r_error     <= 1'b0;
      r_err_count <= 8'd0;
    end else if (w_pop) begin
      r_expected <= w_head + WIDTH'(1);
      if (w_mismatch) begin
        r_error     <= 1'b1;
        r_err_count <= sat_inc8(r_err_count);
      end
    end
  end
`else
  assign o_error     = 1'b0;
  assign o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_pipeline_input.sv
// Testbench for pipeline_input. It uses a queue-based reference model and randomized plus directed streams.
// Expectations for o_error/o_err_count follow PIPELINE_INPUT_CHECK_EN.
module tb_pipeline_input;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
`ifdef PIPELINE_INPUT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] i_value = '0;
  logic             i_valid = 1'b0;
  logic             i_hold = 1'b0;
  logic             i_clear = 1'b0;
  logic             o_ready;
  logic [CNT_W-1:0] o_count;
  logic [WIDTH-1:0] o_last;
  logic             o_error;
  logic [7:0]       o_err_count;

  int n_chk = 0;
  int n_fail = 0;

  pipeline_input #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .i_value(i_value), .i_valid(i_valid),
    .o_ready(o_ready), .i_hold(i_hold), .i_clear(i_clear), .o_count(o_count),
    .o_last(o_last), .o_error(o_error), .o_err_count(o_err_count)
  );

  always #5 clock = ~clock;

  // Reference model state.
  logic [7:0]  mq[$];
  bit          m_ready;
  logic [15:0] m_count;
  logic [7:0]  m_last;
  logic [7:0]  m_exp;
  bit          m_err;
  logic [7:0]  m_errc;
  bit          m_pushed;
  int          dut_acc;
  logic [7:0]  src[$];

  task automatic model_rst();
    mq.delete();
    m_ready = 0; m_count = 0; m_last = 0; m_exp = 0; m_err = 0; m_errc = 0; m_pushed = 0;
  endtask

  task automatic model_step();
    logic [7:0] h;
    bit push, pop;
    push = i_valid && m_ready;
    pop  = (mq.size() > 0) && !i_hold;
    m_pushed = push;
    if (pop) begin
      h = mq.pop_front();
      m_last = h;
      if (!i_clear) begin
        m_count = m_count + 16'd1;
        if (h != m_exp) begin
          m_err = 1;
          if (m_errc != 8'd255) m_errc = m_errc + 8'd1;
        end
        m_exp = h + 8'd1;
      end
    end
    if (i_clear) begin
      m_count = 0; m_err = 0; m_errc = 0; m_exp = 0;
    end
    if (push) mq.push_back(i_value);
    m_ready = (mq.size() != 2);
  endtask

  // Advance one clock, step the model, and leave time at edge+1.
  task automatic tick();
    if (i_valid && o_ready) dut_acc++;
    @(posedge clock);
    if (reset) model_rst(); else model_step();
    #1;
  endtask

  // Present queued source beats for n cycles, holding each until accepted.
  task automatic feed(input int n);
    repeat (n) begin
      if (src.size() > 0) begin
        i_valid = 1'b1;
        i_value = src[0];
      end else begin
        i_valid = 1'b0;
      end
      tick();
      if (m_pushed) void'(src.pop_front());
    end
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_valid = 1'b0; i_hold = 1'b0; i_clear = 1'b0;
    src.delete();
    model_rst();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_rst();
    repeat (2) tick();
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", o_ready); end
    n_chk++; if (o_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
    n_chk++; if (o_last !== 8'd0) begin n_fail++; $display("FAIL reset_last: got %0d want 0", o_last); end
    n_chk++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %0b want 0", o_error); end
    n_chk++; if (o_err_count !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", o_err_count); end
    reset = 1'b0;
    #1;
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %0b want 0", o_ready); end
    tick();
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %0b want 1", o_ready); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) src.push_back(8'(i));
    repeat (12) begin
      feed(1);
      n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready: got %0b want 1", o_ready); end
    end
    n_chk++; if (o_count !== 16'd10) begin n_fail++; $display("FAIL stream_count: got %0d want 10", o_count); end
    n_chk++; if (o_last !== 8'd9) begin n_fail++; $display("FAIL stream_last: got %0d want 9", o_last); end
    n_chk++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL stream_error: got %0b want 0", o_error); end
  endtask

  task automatic test_hold();
    do_reset();
    dut_acc = 0;
    i_hold = 1'b1;
    for (int i = 0; i < 10; i++) src.push_back(8'(i));
    feed(6);
    n_chk++; if (dut_acc != 2) begin n_fail++; $display("FAIL hold_accepts: got %0d want 2", dut_acc); end
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %0b want 0", o_ready); end
    n_chk++; if (o_count !== 16'd0) begin n_fail++; $display("FAIL hold_count: got %0d want 0", o_count); end
    i_hold = 1'b0;
    feed(1);
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %0b want 1", o_ready); end
    feed(1);
    n_chk++; if (o_count !== 16'd2) begin n_fail++; $display("FAIL release_count: got %0d want 2", o_count); end
    feed(12);
    n_chk++; if (dut_acc != 10) begin n_fail++; $display("FAIL hold_total_accepts: got %0d want 10", dut_acc); end
    n_chk++; if (o_count !== 16'd10) begin n_fail++; $display("FAIL hold_final_count: got %0d want 10", o_count); end
    n_chk++; if (o_last !== 8'd9) begin n_fail++; $display("FAIL hold_final_last: got %0d want 9", o_last); end
    n_chk++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL hold_error: got %0b want 0", o_error); end
  endtask

  task automatic test_mismatch();
    do_reset();
    src = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd6};
    feed(5);
    n_chk++; if (o_count !== 16'd4) begin n_fail++; $display("FAIL mm_count4: got %0d want 4", o_count); end
    n_chk++; if (o_err_count !== (CHK ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL mm_errcnt_at5: got %0d want %0d", o_err_count, CHK); end
    feed(5);
    n_chk++; if (o_count !== 16'd5) begin n_fail++; $display("FAIL mm_count5: got %0d want 5", o_count); end
    n_chk++; if (o_error !== CHK) begin n_fail++; $display("FAIL mm_error: got %0b want %0b", o_error, CHK); end
    n_chk++; if (o_err_count !== (CHK ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL mm_errcnt_final: got %0d want %0d", o_err_count, CHK); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) src.push_back(8'(i));
    src.push_back(8'd0);
    feed(262);
    n_chk++; if (o_count !== 16'd257) begin n_fail++; $display("FAIL wrap_count: got %0d want 257", o_count); end
    n_chk++; if (o_last !== 8'd0) begin n_fail++; $display("FAIL wrap_last: got %0d want 0", o_last); end
    n_chk++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL wrap_error: got %0b want 0", o_error); end
  endtask

  task automatic test_clear_collision();
    do_reset();
    src = '{8'd0, 8'd1, 8'd2};
    feed(5);
    i_hold = 1'b1;
    src.push_back(8'd9);
    feed(2);
    i_hold = 1'b0;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    n_chk++; if (o_count !== 16'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", o_count); end
    n_chk++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL clr_error: got %0b want 0", o_error); end
    n_chk++; if (o_err_count !== 8'd0) begin n_fail++; $display("FAIL clr_errcnt: got %0d want 0", o_err_count); end
    n_chk++; if (o_last !== 8'd9) begin n_fail++; $display("FAIL clr_last: got %0d want 9", o_last); end
    src = '{8'd0, 8'd1};
    feed(4);
    n_chk++; if (o_count !== 16'd2) begin n_fail++; $display("FAIL clr_after_count: got %0d want 2", o_count); end
    n_chk++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL clr_after_error: got %0b want 0", o_error); end
  endtask

  task automatic test_reset_full();
    i_hold = 1'b1;
    for (int i = 0; i < 6; i++) src.push_back(8'(i + 40));
    feed(4);
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", o_ready); end
    #2;
    reset = 1'b1;
    #1;
    n_chk++; if (o_count !== 16'd0) begin n_fail++; $display("FAIL async_count: got %0d want 0", o_count); end
    n_chk++; if (o_last !== 8'd0) begin n_fail++; $display("FAIL async_last: got %0d want 0", o_last); end
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready: got %0b want 0", o_ready); end
    src.delete();
    model_rst();
    i_hold = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    src = '{8'd0, 8'd1, 8'd2, 8'd3};
    feed(8);
    n_chk++; if (o_count !== 16'd4) begin n_fail++; $display("FAIL postrst_count: got %0d want 4", o_count); end
    n_chk++; if (o_last !== 8'd3) begin n_fail++; $display("FAIL postrst_last: got %0d want 3", o_last); end
    n_chk++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL postrst_error: got %0b want 0", o_error); end
  endtask

  task automatic test_random();
    logic [7:0] nxt;
    do_reset();
    nxt = 8'd0;
    for (int c = 0; c < 400; c++) begin
      i_hold  = ($urandom_range(0, 3) == 0);
      i_clear = ($urandom_range(0, 40) == 0);
      if (!i_valid && $urandom_range(0, 3) != 0) begin
        i_valid = 1'b1;
        i_value = ($urandom_range(0, 9) == 0) ? 8'($urandom) : nxt;
        nxt = i_value + 8'd1;
      end
      tick();
      if (m_pushed) i_valid = 1'b0;
      n_chk++; if (o_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, o_ready, m_ready); end
      n_chk++; if (o_count !== m_count) begin n_fail++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, o_count, m_count); end
      n_chk++; if (o_last !== m_last) begin n_fail++; $display("FAIL rnd_last c=%0d: got %0d want %0d", c, o_last, m_last); end
      n_chk++; if (o_error !== (m_err & CHK)) begin n_fail++; $display("FAIL rnd_error c=%0d: got %0b want %0b", c, o_error, m_err & CHK); end
      n_chk++; if (o_err_count !== (CHK ? m_errc : 8'd0)) begin n_fail++; $display("FAIL rnd_errcnt c=%0d: got %0d want %0d", c, o_err_count, CHK ? m_errc : 8'd0); end
    end
    i_hold = 1'b0;
    i_clear = 1'b0;
    i_valid = 1'b0;
  endtask

  initial begin
    dut_acc = 0;
    model_rst();
    test_reset();
    test_stream();
    test_hold();
    test_mismatch();
    test_wrap();
    test_clear_collision();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
